// File: rtl/dmem_arbiter_pkg.sv
// Shared types and func3 encodings for the data-memory arbiter.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } dmem_owner_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/dmem_store_align.sv
// Byte-enable / lane-replication generator and misalignment detector for CPU accesses.
module dmem_store_align
  import dmem_arbiter_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_func3,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_mem_we,
  output logic [31:0] o_mem_wdata,
  output logic        o_misaligned
);

  always_comb begin
    o_mem_we     = 4'b0000;
    o_mem_wdata  = i_wdata;
    o_misaligned = 1'b0;
    if (i_we) begin
      case (i_func3)
        F3_SB: begin
          o_mem_we    = 4'b0001 << i_addr;
          o_mem_wdata = {4{i_wdata[7:0]}};
        end
        F3_SH: begin
          o_mem_we     = 4'b0011 << {i_addr[1], 1'b0};
          o_mem_wdata  = {2{i_wdata[15:0]}};
          o_misaligned = i_addr[0];
        end
        // Unknown store sizes behave as a full word, alignment included.
        default: begin
          o_mem_we     = 4'b1111;
          o_misaligned = |i_addr;
        end
      endcase
    end else begin
      case (i_func3)
        F3_LH, F3_LHU: o_misaligned = i_addr[0];
        F3_LW:         o_misaligned = |i_addr;
        default:       o_misaligned = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU (A) and loader/debug (B).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [2:0]        a_func3,
  input  logic [31:0]       a_wdata,
  output logic              a_gnt,
  output logic              a_stall,
  output logic              a_ack,
  output logic              a_err,
  output logic [31:0]       a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wdata,
  output logic              b_gnt,
  output logic              b_ack,
  output logic [31:0]       b_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic [7:0]  r_wait_cnt;
  dmem_owner_t r_owner;
  logic        r_a_err;

  logic        w_starved;
  logic        w_a_misaligned;
  logic [3:0]  w_a_we;
  logic [31:0] w_a_wdata;
  logic        w_unused_b_lsb;

  assign w_unused_b_lsb = ^b_addr[1:0];

  dmem_store_align u_store_align (
    .i_we         (a_we),
    .i_func3      (a_func3),
    .i_addr       (a_addr[1:0]),
    .i_wdata      (a_wdata),
    .o_mem_we     (w_a_we),
    .o_mem_wdata  (w_a_wdata),
    .o_misaligned (w_a_misaligned)
  );

  assign w_starved = b_req && (r_wait_cnt == 8'(MAX_WAIT));

  always_comb begin
    a_gnt     = a_req && !w_starved;
    b_gnt     = b_req && (!a_req || w_starved);
    a_stall   = a_req && !a_gnt;
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = a_addr[ADDR_W-1:2];
    mem_wdata = w_a_wdata;
    if (b_gnt) begin
      mem_en    = 1'b1;
      mem_we    = b_we ? 4'b1111 : 4'b0000;
      mem_addr  = b_addr[ADDR_W-1:2];
      mem_wdata = b_wdata;
    end else if (a_gnt && !w_a_misaligned) begin
      // Misaligned A accesses are granted (to unblock the pipeline) but never reach memory.
      mem_en = 1'b1;
      mem_we = w_a_we;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= 8'd0;
    end else if (!b_req || b_gnt) begin
      r_wait_cnt <= 8'd0;
    end else if (r_wait_cnt != 8'(MAX_WAIT)) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner <= OWN_NONE;
      r_a_err <= 1'b0;
    end else begin
      r_a_err <= a_gnt && w_a_misaligned;
      if (b_gnt)      r_owner <= OWN_B;
      else if (a_gnt) r_owner <= OWN_A;
      else            r_owner <= OWN_NONE;
    end
  end

  always_comb begin
    a_ack   = (r_owner == OWN_A);
    b_ack   = (r_owner == OWN_B);
    a_err   = r_a_err;
    a_rdata = (a_ack && !r_a_err) ? mem_rdata : 32'd0;
    b_rdata = b_ack ? mem_rdata : 32'd0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural synchronous-read memory.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int unsigned ADDR_W = 10;

  logic              clk;
  logic              reset;
  logic              a_req, a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [2:0]        a_func3;
  logic [31:0]       a_wdata;
  logic              a_gnt, a_stall, a_ack, a_err;
  logic [31:0]       a_rdata;
  logic              b_req, b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [31:0]       b_wdata;
  logic              b_gnt, b_ack;
  logic [31:0]       b_rdata;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        port_b;
    logic        err;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];

  logic [31:0] mem [0:255];

  dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(8)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_func3(a_func3), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_stall(a_stall), .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= mem[mem_addr];
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  // Scoreboard: one response expected per issue, checked just after the following edge.
  always @(posedge clk) begin
    exp_t        e;
    logic [31:0] got;
    #2;
    if (reset) begin
      sb_q.delete();
    end else if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (a_ack !== !e.port_b || b_ack !== e.port_b) begin
        failures++;
        $display("FAIL ack_route: a_ack=%b b_ack=%b expected a_ack=%b b_ack=%b",
                 a_ack, b_ack, !e.port_b, e.port_b);
      end
      if (!e.port_b) begin
        checks++;
        if (a_err !== e.err) begin
          failures++;
          $display("FAIL a_err: got %b expected %b", a_err, e.err);
        end
      end
      if (e.chk) begin
        got = e.port_b ? b_rdata : a_rdata;
        checks++;
        if (got !== e.data) begin
          failures++;
          $display("FAIL rdata(port_b=%b): got %h expected %h", e.port_b, got, e.data);
        end
      end
    end else if (a_ack !== 1'b0 || b_ack !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL spurious_ack: a_ack=%b b_ack=%b expected 0 0", a_ack, b_ack);
    end
  end

  function automatic exp_t mk(logic pb, logic err, logic chk, logic [31:0] d);
    exp_t e;
    e.port_b = pb; e.err = err; e.chk = chk; e.data = d;
    return e;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    a_req = 1'b0;
    b_req = 1'b0;
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_ack, b_ack, a_err} !== 3'b000 || a_rdata !== 32'd0 || b_rdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_regs: ack/err=%b%b%b rdata=%h/%h expected 000 0/0",
               a_ack, b_ack, a_err, a_rdata, b_rdata);
    end
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'h010; a_func3 = F3_LW;
    #1;
    checks++;
    if (a_gnt !== 1'b1 || a_stall !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 8'h04) begin
      failures++;
      $display("FAIL reset_comb: gnt=%b stall=%b en=%b addr=%h expected 1 0 1 04",
               a_gnt, a_stall, mem_en, mem_addr);
    end
    a_req = 1'b0;
    next_cycle();
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_load();
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'h010; a_func3 = F3_LW;
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 4'b0000 || mem_addr !== 8'h04) begin
      failures++;
      $display("FAIL load_issue: gnt=%b en=%b we=%b addr=%h expected 1 1 0000 04",
               a_gnt, mem_en, mem_we, mem_addr);
    end
    sb_q.push_back(mk(1'b0, 1'b0, 1'b1, 32'hDEADBEEF));
    next_cycle();
    idle(2);
  endtask

  task automatic test_store();
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'h013; a_func3 = F3_SB; a_wdata = 32'h000000A5;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 4'b1000 || mem_wdata !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL store_sb: en=%b we=%b wdata=%h expected 1 1000 a5a5a5a5",
               mem_en, mem_we, mem_wdata);
    end
    sb_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0));
    next_cycle();
    a_addr = 10'h012; a_func3 = F3_SH; a_wdata = 32'h00001234;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 4'b1100 || mem_wdata !== 32'h12341234) begin
      failures++;
      $display("FAIL store_sh: en=%b we=%b wdata=%h expected 1 1100 12341234",
               mem_en, mem_we, mem_wdata);
    end
    sb_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0));
    next_cycle();
    a_addr = 10'h014; a_func3 = F3_SW; a_wdata = 32'h89ABCDEF;
    @(negedge clk);
    checks++;
    if (mem_we !== 4'b1111 || mem_wdata !== 32'h89ABCDEF || mem_addr !== 8'h05) begin
      failures++;
      $display("FAIL store_sw: we=%b wdata=%h addr=%h expected 1111 89abcdef 05",
               mem_we, mem_wdata, mem_addr);
    end
    sb_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0));
    next_cycle();
    a_we = 1'b0; a_addr = 10'h010; a_func3 = F3_LW;
    sb_q.push_back(mk(1'b0, 1'b0, 1'b1, 32'h1234BEEF));
    next_cycle();
    a_addr = 10'h014;
    sb_q.push_back(mk(1'b0, 1'b0, 1'b1, 32'h89ABCDEF));
    next_cycle();
    idle(2);
  endtask

  task automatic test_misaligned();
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'h006; a_func3 = F3_LW;
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b1 || mem_en !== 1'b0 || mem_we !== 4'b0000) begin
      failures++;
      $display("FAIL mis_lw: gnt=%b en=%b we=%b expected 1 0 0000", a_gnt, mem_en, mem_we);
    end
    sb_q.push_back(mk(1'b0, 1'b1, 1'b1, 32'd0));
    next_cycle();
    a_we = 1'b1; a_func3 = F3_SW; a_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b1 || mem_en !== 1'b0 || mem_we !== 4'b0000) begin
      failures++;
      $display("FAIL mis_sw: gnt=%b en=%b we=%b expected 1 0 0000", a_gnt, mem_en, mem_we);
    end
    sb_q.push_back(mk(1'b0, 1'b1, 1'b1, 32'd0));
    next_cycle();
    a_we = 1'b0; a_addr = 10'h011; a_func3 = F3_LHU;
    sb_q.push_back(mk(1'b0, 1'b1, 1'b1, 32'd0));
    next_cycle();
    a_addr = 10'h006; a_func3 = F3_LH;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1) begin
      failures++;
      $display("FAIL aligned_lh: en=%b expected 1", mem_en);
    end
    sb_q.push_back(mk(1'b0, 1'b0, 1'b1, 32'h11111111));
    next_cycle();
    idle(2);
    checks++;
    if (mem[1] !== 32'h11111111) begin
      failures++;
      $display("FAIL mis_nowrite: mem[1]=%h expected 11111111", mem[1]);
    end
  endtask

  task automatic test_starvation();
    logic exp_b;
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'h000; a_func3 = F3_LW;
    b_req = 1'b1; b_we = 1'b0; b_addr = 10'h020;
    for (int i = 1; i <= 18; i++) begin
      exp_b = (i == 9) || (i == 18);
      @(negedge clk);
      checks++;
      if (b_gnt !== exp_b || a_gnt !== !exp_b || a_stall !== exp_b) begin
        failures++;
        $display("FAIL starve_c%0d: b_gnt=%b a_gnt=%b a_stall=%b expected %b %b %b",
                 i, b_gnt, a_gnt, a_stall, exp_b, !exp_b, exp_b);
      end
      if (exp_b) begin
        checks++;
        if (mem_addr !== 8'h08) begin
          failures++;
          $display("FAIL starve_addr: got %h expected 08", mem_addr);
        end
      end
      sb_q.push_back(mk(exp_b, 1'b0, 1'b1, exp_b ? 32'hB0B0B0B0 : 32'hA0A0A0A0));
      next_cycle();
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    // A rd w16, B wr w20, A rd w20, B rd w17, A rd w18, B rd w16
    for (int i = 0; i < 6; i++) begin
      a_req = (i % 2 == 0);
      b_req = (i % 2 == 1);
      a_we = 1'b0; a_func3 = F3_LW; b_we = 1'b0;
      case (i)
        0: a_addr = 10'd64;
        1: begin b_we = 1'b1; b_addr = 10'd83; b_wdata = 32'hCAFEF00D; end
        2: a_addr = 10'd80;
        3: b_addr = 10'd68;
        4: a_addr = 10'd72;
        default: b_addr = 10'd64;
      endcase
      @(negedge clk);
      if (i == 1) begin
        checks++;
        if (mem_we !== 4'b1111 || mem_addr !== 8'd20 || mem_wdata !== 32'hCAFEF00D) begin
          failures++;
          $display("FAIL b_write: we=%b addr=%h wdata=%h expected 1111 14 cafef00d",
                   mem_we, mem_addr, mem_wdata);
        end
      end
      case (i)
        0: sb_q.push_back(mk(1'b0, 1'b0, 1'b1, 32'h10000010));
        1: sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'd0));
        2: sb_q.push_back(mk(1'b0, 1'b0, 1'b1, 32'hCAFEF00D));
        3: sb_q.push_back(mk(1'b1, 1'b0, 1'b1, 32'h10000011));
        4: sb_q.push_back(mk(1'b0, 1'b0, 1'b1, 32'h10000012));
        default: sb_q.push_back(mk(1'b1, 1'b0, 1'b1, 32'h10000010));
      endcase
      next_cycle();
    end
    idle(2);
  endtask

  task automatic test_reset_midflight();
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'h010; a_func3 = F3_LW;
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
    a_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_ack, b_ack, a_err} !== 3'b000 || a_rdata !== 32'd0 || b_rdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid: ack/err=%b%b%b rdata=%h/%h expected 000 0/0",
               a_ack, b_ack, a_err, a_rdata, b_rdata);
    end
    next_cycle();
    reset = 1'b0;
    idle(3);
    a_req = 1'b1; a_addr = 10'h000;
    @(negedge clk);
    sb_q.push_back(mk(1'b0, 1'b0, 1'b1, 32'hA0A0A0A0));
    next_cycle();
    idle(2);
  endtask

  initial begin
    reset = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_func3 = F3_LW; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h10000000 | i;
    mem[0] = 32'hA0A0A0A0;
    mem[1] = 32'h11111111;
    mem[4] = 32'hDEADBEEF;
    mem[8] = 32'hB0B0B0B0;

    test_reset();
    test_load();
    test_store();
    test_misaligned();
    test_starvation();
    test_back_to_back();
    test_reset_midflight();

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d responses outstanding, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port, synchronous-read data memory between two requesters: port A (pipeline MEM stage) and port B (program loader / debug master).
- Issues at most one access per cycle.
- Generates byte write enables and lane-replicated store data from func3.
- Returns the raw read word one cycle after issue, and flags misaligned CPU accesses.
- Sits between mem_stage and data_memory; load sign/zero formatting stays in mem_stage.

Parameters:
- ADDR_W, 10, byte-address width of both ports; memory word address is ADDR_W-2 bits.
- MAX_WAIT, 8, consecutive cycles port B may be refused before it takes priority over A (1..255).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- a_req  in  1  CPU access request.
- a_we  in  1  CPU store (1) / load (0).
- a_addr  in  ADDR_W  CPU byte address.
- a_func3  in  3  access size (F3_LB/LH/LW/LBU/LHU; stores use SB=000, SH=001, SW=010).
- a_wdata  in  32  store data, right-aligned.
- a_gnt  out  1  combinational; A is issued this cycle.
- a_stall  out  1  a_req & ~a_gnt; freezes the pipeline.
- a_ack  out  1  registered; response for the previous-cycle A issue.
- a_err  out  1  qualified by a_ack; access was misaligned and not performed.
- a_rdata  out  32  raw memory word, valid with a_ack.
- b_req  in  1  loader request.
- b_we  in  1  loader write.
- b_addr  in  ADDR_W  loader byte address; bits [1:0] ignored.
- b_wdata  in  32  loader write word.
- b_gnt  out  1  combinational; B is issued this cycle.
- b_ack  out  1  registered; response for the previous-cycle B issue.
- b_rdata  out  32  raw memory word, valid with b_ack.
- mem_en  out  1  memory access strobe.
- mem_we  out  4  byte write enables.
- mem_addr  out  ADDR_W-2  word address.
- mem_wdata  out  32  lane-aligned write data.
- mem_rdata  in  32  memory read word, valid the cycle after mem_en.

Behaviour:
- Reset (asynchronous, active-high):
  - a_ack, b_ack, a_err = 0.
  - Response owner register = OWN_NONE.
  - Starvation counter = 0.
  - a_rdata, b_rdata = 0.
  - Combinational outputs follow their inputs.
  - Reset mid-transaction drops any in-flight response: no ack is issued after reset deasserts.
- Arbitration (combinational, each cycle):
  - Default: A has priority. a_gnt = a_req; b_gnt = b_req & ~a_req.
  - When b_req=1 and the counter has reached MAX_WAIT: b_gnt=1 and a_gnt=0.
- Starvation counter:
  - Increments (saturating at MAX_WAIT) when b_req & ~b_gnt.
  - Clears when b_gnt=1 or b_req=0.
- Issue and response:
  - Issue cycle N drives mem_en=1, unless the access is a misaligned A access.
  - Owner register <= granted port.
  - Cycle N+1: that port's ack=1 and rdata=mem_rdata. A new issue is allowed in N+1, giving full throughput of 1 access per cycle.
  - Writes are acked the same way; rdata content after a write is don't-care.
  - The requester must change or drop its request after seeing gnt. A held request is re-issued as a new access.
- Misaligned A access:
  - Condition: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - a_gnt=1 (prevents deadlock), but mem_en=0 and mem_we=0.
  - Next cycle: a_ack=1, a_err=1, a_rdata=0.
- Store alignment (A port):
  - SB: mem_we = 4'b0001<<addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - SH: mem_we = 4'b0011<<{addr[1],1'b0}; mem_wdata = {2{wdata[15:0]}}.
  - SW: mem_we = 4'b1111; mem_wdata = wdata.
  - Other func3 values on a store: treated as SW.
  - B writes: always 4'b1111 with b_wdata.
- Loads: mem_we = 0.
- mem_addr = granted addr[ADDR_W-1:2]. When idle, mem_en=0 and mem_we=0; mem_addr and mem_wdata are don't-care.

Decomposition:
- Package common gains:
  - dmem_owner_t enum {OWN_NONE, OWN_A, OWN_B}.
  - Store func3 constants F3_SB/F3_SH/F3_SW, alongside the existing load func3 constants.
- One combinational sub-module, dmem_store_align: inputs func3, addr[1:0], wdata; outputs mem_we, mem_wdata, misaligned.
- Arbitration, counter and response register stay in dmem_arbiter.

Test Plan:
- A loads word addr 0x010 (memory holds 0xDEADBEEF): a_gnt=1 with mem_addr=0x004 in cycle N; a_ack=1, a_rdata=0xDEADBEEF, a_err=0 in N+1.
- A SB at 0x013 with wdata=0x000000A5: mem_we=4'b1000, mem_wdata=0xA5A5A5A5. SH at 0x012 with wdata 0x1234: mem_we=4'b1100, mem_wdata=0x12341234.
- A LW at 0x006: mem_en=0; next cycle a_ack=1, a_err=1, a_rdata=0; no memory change.
- a_req held high continuously with b_req high (MAX_WAIT=8): B is refused for 8 cycles, b_gnt=1 on cycle 9 with a_stall=1, then A resumes and the counter reads 0.
- Alternate A/B issues back-to-back for 6 cycles: exactly one ack per cycle, routed to the correct port in issue order.
- Assert reset in the cycle after an A issue: a_ack stays 0 and all registered outputs read 0 until the next issue after reset release.
